// File: rtl/hex_ascii_pkg.sv
// Shared FSM encoding and ASCII constants for the hex-to-ASCII streamer.
package hex_ascii_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational converter from one hex nibble to its ASCII digit.
module hex_nibble_to_ascii
  import hex_ascii_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       lower_case,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nibble};
    end else begin
      ascii = (lower_case ? ASCII_LA : ASCII_UA) + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_ascii_streamer.sv
// Streams a captured hex value as ASCII characters, MSB nibble first,
// optionally suppressing leading zeros and appending CR/LF.
module hex_ascii_streamer
  import hex_ascii_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int APPEND_CRLF = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] hex_in,
  input  logic              lower_case,
  input  logic              zero_suppress,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t            state, state_nx;
  logic [DATA_W-1:0] value;
  logic              lc;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  msnz;
  logic [IDX_W-1:0]  start_idx;
  logic              accept;
  logic              out_fire;
  logic              last_nib;
  logic [DATA_W-1:0] shifted;
  logic [3:0]        nibble;
  logic [7:0]        digit;

  assign in_ready  = (state == IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_nib  = (idx == '0);

  // Ascending scan: the highest non-zero nibble is the last one written.
  // An all-zero value leaves index 0, which emits a single '0'.
  always_comb begin
    msnz = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (hex_in[4*i +: 4] != 4'h0) msnz = IDX_W'(i);
    end
  end

  assign start_idx = zero_suppress ? msnz : IDX_W'(NIB - 1);

  assign shifted = value >> {idx, 2'b00};
  assign nibble  = shifted[3:0];

  hex_nibble_to_ascii u_conv (
    .nibble     (nibble),
    .lower_case (lc),
    .ascii      (digit)
  );

  always_comb begin
    state_nx = state;
    out_data = '0;
    out_last = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = DIGIT;
      end
      DIGIT: begin
        out_data = digit;
        out_last = (APPEND_CRLF == 0) && last_nib;
        if (out_fire && last_nib) state_nx = (APPEND_CRLF != 0) ? CR : IDLE;
      end
      CR: begin
        out_data = ASCII_CR;
        if (out_fire) state_nx = LF;
      end
      LF: begin
        out_data = ASCII_LF;
        out_last = 1'b1;
        if (out_fire) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      value <= '0;
      lc    <= 1'b0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        value <= hex_in;
        lc    <= lower_case;
        idx   <= start_idx;
      end else if (state == DIGIT && out_fire && !last_nib) begin
        idx <= idx - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Directed bench for hex_ascii_streamer: 16-bit with CR/LF and 32-bit without.
module tb_hex_ascii_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, in_ready, lower_case = 1'b0, zero_suppress = 1'b0;
  logic [15:0] hex_in = '0;
  logic        out_valid, out_ready = 1'b1, out_last, busy;
  logic [7:0]  out_data;

  logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b1, out_last32, busy32;
  logic [31:0] hex_in32 = '0;
  logic [7:0]  out_data32;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hex_ascii_streamer #(.DATA_W(16), .APPEND_CRLF(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .hex_in(hex_in), .lower_case(lower_case), .zero_suppress(zero_suppress),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  hex_ascii_streamer #(.DATA_W(32), .APPEND_CRLF(0)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .hex_in(hex_in32), .lower_case(1'b0), .zero_suppress(1'b0),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
    .out_last(out_last32), .busy(busy32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one value to the 16-bit instance with out_ready=1 and checks each
  // character on consecutive cycles; pulse_at>=0 injects a 0xFFFF request there.
  task automatic run16(input string name, input logic [15:0] val, input logic lc,
                       input logic zs, input logic [7:0] exp [8], input int n,
                       input int pulse_at);
    hex_in = val; lower_case = lc; zero_suppress = zs; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({name, " busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == pulse_at) begin
        check({name, " in_ready mid"}, 32'(in_ready), 32'd0);
        hex_in = 16'hFFFF; in_valid = 1'b1;
      end
      check($sformatf("%s vld[%0d]", name, i), 32'(out_valid), 32'd1);
      check($sformatf("%s data[%0d]", name, i), 32'(out_data), 32'(exp[i]));
      check($sformatf("%s last[%0d]", name, i), 32'(out_last), 32'(i == n - 1));
      step();
      in_valid = 1'b0;
    end
    check({name, " in_ready after"}, 32'(in_ready), 32'd1);
    check({name, " out_valid after"}, 32'(out_valid), 32'd0);
    step();
    check({name, " idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] e [8];
    logic [7:0] e32 [8];

    #12;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    e = '{8'h33, 8'h41, 8'h46, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00};
    run16("3AF0", 16'h3AF0, 1'b0, 1'b0, e, 6, -1);

    e = '{8'h62, 8'h65, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    run16("00BE", 16'h00BE, 1'b1, 1'b1, e, 4, -1);

    e = '{8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run16("0000zs", 16'h0000, 1'b0, 1'b1, e, 3, -1);

    e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00};
    run16("0000", 16'h0000, 1'b0, 1'b0, e, 6, -1);

    e = '{8'h39, 8'h63, 8'h30, 8'h64, 8'h0D, 8'h0A, 8'h00, 8'h00};
    run16("9C0D", 16'h9C0D, 1'b1, 1'b0, e, 6, -1);

    e = '{8'h31, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run16("0001zs", 16'h0001, 1'b0, 1'b1, e, 3, -1);

    e = '{8'h33, 8'h41, 8'h46, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00};
    run16("ignore", 16'h3AF0, 1'b0, 1'b0, e, 6, 1);

    // Backpressure on the second character of 0x1234
    hex_in = 16'h1234; lower_case = 1'b0; zero_suppress = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("stall c0", 32'(out_data), 32'h31);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall vld%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("stall hold%0d", i), 32'(out_data), 32'h32);
      check($sformatf("stall last%0d", i), 32'(out_last), 32'd0);
      step();
    end
    out_ready = 1'b1;
    check("stall c1", 32'(out_data), 32'h32);
    step();
    check("stall c2", 32'(out_data), 32'h33);
    step();
    check("stall c3", 32'(out_data), 32'h34);
    step();
    check("stall cr", 32'(out_data), 32'h0D);
    step();
    check("stall lf", 32'(out_data), 32'h0A);
    check("stall lf last", 32'(out_last), 32'd1);
    step();
    check("stall done", 32'(in_ready), 32'd1);
    step();

    // Reset while the third character is presented
    hex_in = 16'h1234; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("rstmid c2", 32'(out_data), 32'h33);
    rst_n = 1'b0;
    #1;
    check("rstmid out_valid", 32'(out_valid), 32'd0);
    check("rstmid out_data", 32'(out_data), 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("rstmid in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rstmid quiet%0d", i), 32'(out_valid), 32'd0);
      step();
    end

    // 32-bit instance without CR/LF
    e32 = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
    hex_in32 = 32'hDEADBEEF; in_valid32 = 1'b1;
    step();
    in_valid32 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("dw32 vld[%0d]", i), 32'(out_valid32), 32'd1);
      check($sformatf("dw32 data[%0d]", i), 32'(out_data32), 32'(e32[i]));
      check($sformatf("dw32 last[%0d]", i), 32'(out_last32), 32'(i == 7));
      step();
    end
    check("dw32 in_ready", 32'(in_ready32), 32'd1);
    check("dw32 out_valid", 32'(out_valid32), 32'd0);
    check("dw32 busy", 32'(busy32), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hex_ascii_streamer.md
HEX_ASCII_STREAMER -- requirements
Module: hex_ascii_streamer

Interface
REQ-001 Parameter DATA_W, 16, width of hex value; SHALL be a multiple of 4 in the range 4..64.
REQ-002 Parameter APPEND_CRLF, 1, when 1 the block SHALL append CR (0x0D) then LF (0x0A) after the last digit.
REQ-003 Port clk, input, 1, single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, hex_in and the mode inputs are valid.
REQ-006 Port in_ready, output, 1, block can accept a new value.
REQ-007 Port hex_in, input, DATA_W, value to convert, MSB nibble first.
REQ-008 Port lower_case, input, 1, when 1 digits 10..15 map to 'a'..'f' (0x61..0x66), otherwise 'A'..'F' (0x41..0x46); sampled on accept.
REQ-009 Port zero_suppress, input, 1, when 1 leading zero nibbles are skipped; sampled on accept.
REQ-010 Port out_valid, output, 1, out_data holds a valid character.
REQ-011 Port out_ready, input, 1, sink accepts the character.
REQ-012 Port out_data, output, 8, ASCII character.
REQ-013 Port out_last, output, 1, qualifies the final character of the current string.
REQ-014 Port busy, output, 1, high from accept until the last character is consumed.

Function
REQ-015 in_ready SHALL equal (state == IDLE); an accept occurs on in_valid && in_ready.
REQ-016 On accept, the block SHALL register hex_in, lower_case and zero_suppress, and SHALL present the first character with out_valid=1 on the next cycle (latency 1).
REQ-017 The FSM SHALL have states IDLE, DIGIT, CR and LF: IDLE->DIGIT on accept; DIGIT->DIGIT on a handshake that is not at the last nibble; DIGIT->CR on the last nibble handshake if APPEND_CRLF=1, otherwise DIGIT->IDLE; CR->LF on handshake; LF->IDLE on handshake.
REQ-018 Nibble mapping: 0..9 SHALL map to 0x30..0x39, and 10..15 SHALL map according to REQ-008.
REQ-019 With zero_suppress=1, the first digit SHALL be the most significant non-zero nibble, found at accept by a priority encoder; an all-zero value SHALL emit a single '0'.
REQ-020 With zero_suppress=0, exactly DATA_W/4 digits SHALL be emitted.
REQ-021 A character SHALL advance only on out_valid && out_ready; while out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-022 out_last SHALL be 1 on LF when APPEND_CRLF=1, or on the last digit when APPEND_CRLF=0, and 0 otherwise.
REQ-023 in_valid SHALL be ignored while not IDLE, and no value SHALL be queued.
REQ-024 A final handshake SHALL return the FSM to IDLE, with in_ready=1 and out_valid=0 on the next cycle; there are no back-to-back strings in the same cycle.
REQ-025 busy SHALL equal !in_ready.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, out_valid=0, out_data=0x00, out_last=0, and the digit index and captured value are cleared.
REQ-027 A reset asserted mid-string SHALL abort the string; after deassertion no remaining characters SHALL be emitted and in_ready=1 on the first clock edge.

Structure
REQ-028 Package hex_ascii_pkg SHALL hold the FSM state encoding and the constants ASCII_0=0x30, ASCII_UA=0x41, ASCII_LA=0x61, ASCII_CR=0x0D and ASCII_LF=0x0A.
REQ-029 Sub-module hex_nibble_to_ascii SHALL be a combinational nibble-to-character converter (inputs: nibble, lower_case), instantiated once on the selected nibble.
REQ-030 The nibble index counter SHALL be $clog2(DATA_W/4) bits wide (minimum 1) and count down from the start nibble to 0.

Verification
REQ-031 DATA_W=16, hex_in=0x3AF0, upper case, no suppress, out_ready=1 SHALL give 0x33,0x41,0x46,0x30,0x0D,0x0A on consecutive cycles, with out_last only on 0x0A and in_ready=1 the cycle after.
REQ-032 hex_in=0x00BE, lower_case=1, zero_suppress=1 SHALL give 0x62,0x65,0x0D,0x0A.
REQ-033 hex_in=0x0000, zero_suppress=1 SHALL give 0x30,0x0D,0x0A; the same value with zero_suppress=0 SHALL give four 0x30 characters then CR and LF.
REQ-034 For 0x1234 with out_ready held low 3 cycles while 0x32 is presented, out_data SHALL stay 0x32 and the stream SHALL resume with 0x33, with nothing lost or duplicated.
REQ-035 A second in_valid pulse with 0xFFFF during a string SHALL be ignored, with the original string intact.
REQ-036 rst_n pulsed low while the 3rd character is presented SHALL force out_valid=0 immediately and emit no further characters, and in_ready=1 after release.
REQ-037 The bench SHALL also cover DATA_W=32 and APPEND_CRLF=0: 0xDEADBEEF SHALL give 8 characters with out_last on 0x46.
